// File: rtl/clock_disp_pkg.sv
// Shared definitions for the clock display path: digit-word layout, special codes, scan states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int WORD_W     = 6;

  // Digit word = {blink, dot_off, code[3:0]}
  localparam int BLINK_BIT = 5;
  localparam int DOT_BIT   = 4;
  localparam int CODE_MSB  = 3;
  localparam int CODE_LSB  = 0;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  typedef logic [WORD_W-1:0] digit_word_t;

  // Power-up word: code 0, decimal point off, not blinking.
  localparam digit_word_t RESET_WORD = 6'b010000;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_controller_if.sv
// Digit-word input bus plus anode/segment pin outputs of the scan controller.
// Latency: n/a (wiring only).
// Backpressure: none; the controller samples digits_in only at frame boundaries.
interface seg_scan_controller_if;
  import clock_disp_pkg::*;

  logic [NUM_DIGITS*WORD_W-1:0] digits_in;
  logic                         load_en;
  logic [NUM_DIGITS-1:0]        an_n;
  logic [6:0]                   seg_n;
  logic                         dp_n;
  logic                         frame_start;
  logic                         blink_phase;

  // Display/edit logic side
  modport master (
    output digits_in, load_en,
    input  an_n, seg_n, dp_n, frame_start, blink_phase
  );

  // Scan controller side
  modport slave (
    input  digits_in, load_en,
    output an_n, seg_n, dp_n, frame_start, blink_phase
  );

endinterface

// File: rtl/seg7_decode.sv
// Maps a 4-bit digit code to active-low segments {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  // Codes 0-9 are decimal glyphs, 10 is a dash, everything else is dark.
  always_comb begin
    seg_n = 7'h7F;
    case (code)
      4'd0:      seg_n = 7'h40;
      4'd1:      seg_n = 7'h79;
      4'd2:      seg_n = 7'h24;
      4'd3:      seg_n = 7'h30;
      4'd4:      seg_n = 7'h19;
      4'd5:      seg_n = 7'h12;
      4'd6:      seg_n = 7'h02;
      4'd7:      seg_n = 7'h78;
      4'd8:      seg_n = 7'h00;
      4'd9:      seg_n = 7'h10;
      CODE_DASH: seg_n = 7'h3F;
      default:   seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Scans eight 7-segment digits one anode at a time with dead-time blanking and blink gating.
// Latency: outputs registered from the next state, so they move on the same edge as the FSM.
// Backpressure: none; digit words are captured into a shadow only at frame boundaries.
module seg_scan_controller
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_controller_if.slave  disp
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // One slot counter serves both phases, so it is as wide as the longer one.
  localparam int CNT_W   = (SCAN_W > BLANK_W) ? SCAN_W : BLANK_W;

  localparam logic [CNT_W-1:0]   SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  scan_state_t state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             boundary;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_nxt;

  logic [NUM_DIGITS-1:0][WORD_W-1:0] shadow;

  digit_word_t           word_nxt;
  logic [6:0]            dec_seg;
  logic                  visible;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  // FSM state register: scan state, digit index and slot counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      idx   <= 3'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state: BLANK then SHOW per digit; leaving SHOW of digit 7 is the frame boundary.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + CNT_W'(1);
    boundary  = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SCAN_LAST) begin
          state_nxt = ST_BLANK;
          idx_nxt   = idx + 3'd1;
          cnt_nxt   = '0;
          boundary  = (idx == 3'd7);
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Free-running blink divider; phase starts visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt        <= '0;
      disp.blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt        <= '0;
      disp.blink_phase <= blink_nxt;
    end else begin
      blink_cnt        <= blink_cnt + BLINK_W'(1);
      disp.blink_phase <= blink_nxt;
    end
  end

  assign blink_nxt = (blink_cnt == BLINK_LAST) ? ~disp.blink_phase : disp.blink_phase;

  // Shadow capture only at the frame boundary keeps each frame tear-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= {NUM_DIGITS{RESET_WORD}};
    end else if (boundary && disp.load_en) begin
      shadow <= disp.digits_in;
    end
  end

  seg7_decode u_dec (
    .code  (word_nxt[CODE_MSB:CODE_LSB]),
    .seg_n (dec_seg)
  );

  // FSM outputs from the next state; a blinking digit in its dark phase looks like BLANK.
  always_comb begin
    word_nxt = shadow[idx_nxt];
    visible  = (state_nxt == ST_SHOW) && !(word_nxt[BLINK_BIT] && !blink_nxt);
    an_nxt   = '1;
    seg_nxt  = 7'h7F;
    dp_nxt   = 1'b1;
    if (visible) begin
      an_nxt  = ~(NUM_DIGITS'(1) << idx_nxt);
      seg_nxt = dec_seg;
      dp_nxt  = word_nxt[DOT_BIT];
    end
  end

  // Pin registers so the board sees glitch-free anode/segment changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp.an_n        <= '1;
      disp.seg_n       <= 7'h7F;
      disp.dp_n        <= 1'b1;
      disp.frame_start <= 1'b0;
    end else begin
      disp.an_n        <= an_nxt;
      disp.seg_n       <= seg_nxt;
      disp.dp_n        <= dp_nxt;
      disp.frame_start <= boundary;
    end
  end

endmodule
